// File: rtl/cpu_pkg.sv
// Shared types and constants for the PC fetch unit.
package cpu_pkg;

  localparam int unsigned PC_W    = 31;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned CNT_W   = 32;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    ISSUE      = 2'd2,
    WAIT_CTL   = 2'd3
  } fetch_state_e;

  localparam pc_t RESET_PC_DEFAULT = '0;

endpackage : cpu_pkg

// File: rtl/pc_fetch_if.sv
// Fetch-unit bus bundle: instruction memory, decode handshake and read-stage PC decision.
interface pc_fetch_if;
  import cpu_pkg::*;

  logic   mem_req;
  pc_t    mem_addr;
  logic   mem_gnt;
  logic   mem_rvalid;
  instr_t mem_rdata;

  logic   ins_valid;
  instr_t ins_data;
  pc_t    ins_pc;
  logic   ins_ready;

  logic   ctl_valid;
  logic   i_pc_set;
  logic   i_pc_add;
  logic   i_pc_inc;
  pc_t    i_pc;

  // Fetch-unit side
  modport master (
    output mem_req, mem_addr, ins_valid, ins_data, ins_pc,
    input  mem_gnt, mem_rvalid, mem_rdata, ins_ready,
    input  ctl_valid, i_pc_set, i_pc_add, i_pc_inc, i_pc
  );

  // Memory / decode / read-stage side
  modport slave (
    input  mem_req, mem_addr, ins_valid, ins_data, ins_pc,
    output mem_gnt, mem_rvalid, mem_rdata, ins_ready,
    output ctl_valid, i_pc_set, i_pc_add, i_pc_inc, i_pc
  );

endinterface : pc_fetch_if

// File: rtl/pc_next.sv
// Next-PC selection: set > add > inc, otherwise hold; all arithmetic wraps at PC width.
module pc_next
  import cpu_pkg::*;
(
  input  pc_t  pc_i,
  input  logic set_i,
  input  logic add_i,
  input  logic inc_i,
  input  pc_t  ofs_i,
  output pc_t  next_pc_c_o
);

  // Priority mux over the three update forms; carry out of the PC width is dropped
  always_comb begin
    next_pc_c_o = pc_i;
    if (set_i) begin
      next_pc_c_o = ofs_i;
    end else if (add_i) begin
      next_pc_c_o = pc_i + ofs_i;
    end else if (inc_i) begin
      next_pc_c_o = pc_i + pc_t'(1);
    end
  end

endmodule : pc_next

// File: rtl/pc_fetch.sv
// Non-pipelined fetch unit: one instruction in flight, PC updated by the read-stage decision.
module pc_fetch
  import cpu_pkg::*;
#(
  parameter pc_t RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  pc_fetch_if.master        bus,
  output pc_t               pc,
  output cnt_t              instret
);

  fetch_state_e state_q, state_d;
  pc_t          pc_q, pc_d;
  logic         mem_req_q, mem_req_d;
  logic         ins_valid_q, ins_valid_d;
  instr_t       ins_data_q, ins_data_d;
  pc_t          ins_pc_q, ins_pc_d;
  cnt_t         instret_q, instret_d;
  pc_t          next_pc_c;

  pc_next u_pc_next (
    .pc_i        (pc_q),
    .set_i       (bus.i_pc_set),
    .add_i       (bus.i_pc_add),
    .inc_i       (bus.i_pc_inc),
    .ofs_i       (bus.i_pc),
    .next_pc_c_o (next_pc_c)
  );

  // State and datapath registers
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state_q     <= FETCH_REQ;
      pc_q        <= RESET_PC;
      mem_req_q   <= 1'b0;
      ins_valid_q <= 1'b0;
      ins_data_q  <= '0;
      ins_pc_q    <= '0;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_req_q   <= mem_req_d;
      ins_valid_q <= ins_valid_d;
      ins_data_q  <= ins_data_d;
      ins_pc_q    <= ins_pc_d;
      instret_q   <= instret_d;
    end
  end

  // Next state and register updates; a grant only counts once the request is actually on the bus
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_req_d   = mem_req_q;
    ins_valid_d = ins_valid_q;
    ins_data_d  = ins_data_q;
    ins_pc_d    = ins_pc_q;
    instret_d   = instret_q;

    case (state_q)
      FETCH_REQ: begin
        mem_req_d = 1'b1;
        if (mem_req_q && bus.mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (bus.mem_rvalid) begin
          ins_data_d  = bus.mem_rdata;
          ins_pc_d    = pc_q;
          ins_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.ins_ready) begin
          ins_valid_d = 1'b0;
          state_d     = WAIT_CTL;
        end
      end
      WAIT_CTL: begin
        if (bus.ctl_valid) begin
          pc_d      = next_pc_c;
          instret_d = instret_q + cnt_t'(1);
          mem_req_d = 1'b1;
          state_d   = FETCH_REQ;
        end
      end
      default: begin
        state_d = FETCH_REQ;
      end
    endcase
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = pc_q;
  assign bus.ins_valid = ins_valid_q;
  assign bus.ins_data  = ins_data_q;
  assign bus.ins_pc    = ins_pc_q;
  assign pc            = pc_q;
  assign instret       = instret_q;

endmodule : pc_fetch

// File: tb/tb_pc_fetch.sv
// Randomized self-checking bench for pc_fetch against a transaction-level PC model.
module tb_pc_fetch;
  import cpu_pkg::*;

  logic        cpu_clk;
  logic        cpu_rst;
  pc_t         pc;
  logic [31:0] instret;

  pc_fetch_if bus ();

  pc_fetch dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .bus     (bus),
    .pc      (pc),
    .instret (instret)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: architectural PC and retired-decision count
  longint m_pc;
  longint m_instret;
  localparam longint PC_MOD = 64'sd1 << 31;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  // Decision rule: set beats add beats inc; none means stay; arithmetic modulo 2^31
  function automatic longint ref_next(input longint cur, input logic [2:0] fl, input longint ofs);
    if (fl[2]) return ofs;
    if (fl[1]) return (cur + ofs) % PC_MOD;
    if (fl[0]) return (cur + 1) % PC_MOD;
    return cur;
  endfunction

  task automatic idle_inputs();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    bus.ins_ready  = 1'b0;
    bus.ctl_valid  = 1'b0;
    bus.i_pc_set   = 1'b0;
    bus.i_pc_add   = 1'b0;
    bus.i_pc_inc   = 1'b0;
    bus.i_pc       = '0;
  endtask

  // Drive an ignored ctl decision with random flags (used outside WAIT_CTL)
  task automatic noise_ctl(input bit en);
    bus.ctl_valid = en & 1'($urandom_range(0, 1));
    bus.i_pc_set  = 1'($urandom);
    bus.i_pc_add  = 1'($urandom);
    bus.i_pc_inc  = 1'($urandom);
    bus.i_pc      = pc_t'($urandom);
  endtask

  task automatic check_idle_regs(input string tag);
    chk({tag, "_pc"}, 32'(pc), 32'(m_pc));
    chk({tag, "_instret"}, instret, 32'(m_instret));
  endtask

  // One full fetch/issue/decide transaction with given delays and decision
  task automatic txn(input int gd, input int rvd, input int rdd, input int cd,
                     input logic [15:0] rd, input logic [2:0] fl, input logic [30:0] ipc,
                     input bit noise);
    int n;
    n = 0;
    while (bus.mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("req_up", 32'(bus.mem_req), 32'd1);
    chk("req_addr", 32'(bus.mem_addr), 32'(m_pc));
    for (int i = 0; i < gd; i++) begin
      noise_ctl(noise);
      bus.mem_rvalid = noise & 1'($urandom_range(0, 1));
      bus.mem_rdata  = instr_t'($urandom);
      tick();
      chk("req_hold", 32'(bus.mem_req), 32'd1);
      chk("addr_hold", 32'(bus.mem_addr), 32'(m_pc));
    end
    idle_inputs();
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    chk("req_drop", 32'(bus.mem_req), 32'd0);
    for (int i = 1; i < rvd; i++) begin
      noise_ctl(noise);
      tick();
      chk("no_ins_early", 32'(bus.ins_valid), 32'd0);
    end
    idle_inputs();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rd;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("ins_valid", 32'(bus.ins_valid), 32'd1);
    chk("ins_data", 32'(bus.ins_data), 32'(rd));
    chk("ins_pc", 32'(bus.ins_pc), 32'(m_pc));
    check_idle_regs("fetch_wait");
    for (int i = 0; i < rdd; i++) begin
      noise_ctl(noise);
      bus.mem_rvalid = noise & 1'($urandom_range(0, 1));
      bus.mem_rdata  = instr_t'($urandom);
      tick();
      chk("ins_valid_hold", 32'(bus.ins_valid), 32'd1);
      chk("ins_data_hold", 32'(bus.ins_data), 32'(rd));
      chk("ins_pc_hold", 32'(bus.ins_pc), 32'(m_pc));
    end
    idle_inputs();
    noise_ctl(noise);
    bus.ins_ready = 1'b1;
    tick();
    idle_inputs();
    chk("ins_valid_drop", 32'(bus.ins_valid), 32'd0);
    check_idle_regs("issue");
    for (int i = 0; i < cd; i++) begin
      tick();
      chk("wait_req", 32'(bus.mem_req), 32'd0);
    end
    bus.ctl_valid = 1'b1;
    bus.i_pc_set  = fl[2];
    bus.i_pc_add  = fl[1];
    bus.i_pc_inc  = fl[0];
    bus.i_pc      = ipc;
    tick();
    idle_inputs();
    m_pc      = ref_next(m_pc, fl, longint'(ipc));
    m_instret = (m_instret + 1) % (64'sd1 << 32);
    check_idle_regs("ctl");
    chk("ctl_req", 32'(bus.mem_req), 32'd1);
    chk("ctl_addr", 32'(bus.mem_addr), 32'(m_pc));
  endtask

  initial begin
    idle_inputs();
    m_pc      = 0;
    m_instret = 0;
    cpu_rst   = 1'b0;
    repeat (3) @(posedge cpu_clk);
    #1;
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_valid", 32'(bus.ins_valid), 32'd0);
    chk("rst_data", 32'(bus.ins_data), 32'd0);
    chk("rst_ins_pc", 32'(bus.ins_pc), 32'd0);
    check_idle_regs("rst");
    #2 cpu_rst = 1'b1;
    tick();
    chk("req_rise", 32'(bus.mem_req), 32'd1);
    chk("req_rise_addr", 32'(bus.mem_addr), 32'd0);

    // Basic fetch, rvalid two cycles after grant, increment
    txn(0, 2, 0, 0, 16'hA5C3, 3'b001, 31'h0, 1'b0);
    // Priority: set with inc, then add of -1
    txn(1, 1, 0, 1, 16'h1111, 3'b100, 31'h10, 1'b0);
    txn(0, 1, 1, 0, 16'h2222, 3'b101, 31'h200, 1'b0);
    txn(0, 3, 0, 0, 16'h3333, 3'b010, 31'h7FFF_FFFF, 1'b0);
    // Wrap at the top of the PC range, then halt loop with no flags
    txn(0, 1, 0, 0, 16'h4444, 3'b100, 31'h7FFF_FFFF, 1'b0);
    txn(0, 1, 0, 0, 16'h5555, 3'b001, 31'h0, 1'b0);
    txn(0, 1, 0, 0, 16'h6666, 3'b000, 31'h1234, 1'b0);
    // Slow grant and slow decode with ignored noise on ctl/rvalid
    txn(5, 2, 3, 2, 16'h7777, 3'b001, 31'h0, 1'b1);

    // Reset while waiting for read data; stale response must be dropped
    begin
      bus.mem_gnt = 1'b1;
      tick();
      bus.mem_gnt = 1'b0;
      #2 cpu_rst = 1'b0;
      #1;
      chk("midrst_req", 32'(bus.mem_req), 32'd0);
      chk("midrst_valid", 32'(bus.ins_valid), 32'd0);
      m_pc      = 0;
      m_instret = 0;
      check_idle_regs("midrst");
      #2 cpu_rst = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 16'hDEAD;
      tick();
      chk("stale_valid0", 32'(bus.ins_valid), 32'd0);
      chk("stale_req", 32'(bus.mem_req), 32'd1);
      tick();
      bus.mem_rvalid = 1'b0;
      chk("stale_valid1", 32'(bus.ins_valid), 32'd0);
      check_idle_regs("stale");
    end

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      logic [30:0] ipc;
      ipc = ($urandom_range(0, 1) == 0) ? 31'($urandom_range(0, 64)) : 31'($urandom);
      if ($urandom_range(0, 3) == 0) ipc = 31'h7FFF_FFFF - 31'($urandom_range(0, 3));
      txn(int'($urandom_range(0, 4)), int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), 16'($urandom), 3'($urandom_range(0, 7)), ipc, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pc_fetch
